// File: rtl/hilo_mdu.sv
// Iterative 32-bit multiply/divide unit for MULT/MULTU/DIV/DIVU.
// It stalls the pipeline while working and emits a single-cycle HI/LO write.
module hilo_mdu (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        cancel,
    output logic        stallreq,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_wdata,
    output logic [31:0] lo_wdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
    logic [31:0] opnd_q, opnd_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_hold_q, hi_hold_d;
    logic [31:0] lo_hold_q, lo_hold_d;

    logic        accept;
    logic        s1_neg, s2_neg;
    logic [31:0] abs1, abs2;
    logic [32:0] mul_sum;
    logic [32:0] div_top, div_diff;
    logic        div_ge;
    logic [63:0] prod;
    logic [31:0] quot, rem;
    logic [31:0] res_hi, res_lo;
    logic        write;

    // Datapath: operand magnitudes, one radix-2 step, and sign correction of the final value.
    always_comb begin
        accept   = start & ~cancel;
        s1_neg   = op[0] & src1[31];
        s2_neg   = op[0] & src2[31];
        abs1     = s1_neg ? (32'd0 - src1) : src1;
        abs2     = s2_neg ? (32'd0 - src2) : src2;

        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_top  = acc_q[63:31];
        div_ge   = (div_top >= {1'b0, opnd_q});
        div_diff = div_top - (div_ge ? {1'b0, opnd_q} : 33'd0);

        prod     = neg_res_q ? (64'd0 - acc_q) : acc_q;
        quot     = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem      = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

        // A zero divisor leaves the dividend magnitude as remainder, so only LO needs overriding.
        if (is_div_q) begin
            res_hi = rem;
            res_lo = div0_q ? 32'hFFFF_FFFF : quot;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        hi_hold_d = hi_hold_q;
        lo_hold_d = lo_hold_q;
        stallreq  = 1'b0;
        write     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    stallreq  = 1'b1;
                    state_d   = BUSY;
                    cnt_d     = 6'd0;
                    is_div_d  = op[1];
                    neg_res_d = s1_neg ^ s2_neg;
                    neg_rem_d = s1_neg;
                    div0_d    = op[1] & (src2 == 32'd0);
                    if (op[1]) begin
                        acc_d  = {32'd0, abs1};
                        opnd_d = abs2;
                    end else begin
                        acc_d  = {32'd0, abs2};
                        opnd_d = abs1;
                    end
                end
            end
            BUSY: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    stallreq = 1'b1;
                    acc_d    = is_div_q ? {div_diff[31:0], acc_q[30:0], div_ge}
                                        : {mul_sum, acc_q[31:1]};
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!cancel) begin
                    write     = 1'b1;
                    hi_hold_d = res_hi;
                    lo_hold_d = res_lo;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hi_we    = write;
    assign lo_we    = write;
    assign hi_wdata = write ? res_hi : hi_hold_q;
    assign lo_wdata = write ? res_lo : lo_hold_q;

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            opnd_q    <= 32'd0;
            acc_q     <= 64'd0;
            hi_hold_q <= 32'd0;
            lo_hold_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            hi_hold_q <= hi_hold_d;
            lo_hold_q <= lo_hold_d;
        end
    end

endmodule
